// File: rtl/pet_loader_pkg.sv
// Shared state type, zero-page pointer addresses and patch helpers for the PET DMA loader.
// PET_LOADER_FULLPATCH_EN selects the 6-byte BASIC pointer patch instead of the 2-byte one.
package pet_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_LO,
      ST_HDR_HI,
      ST_PRG_DATA,
      ST_ROM_DATA,
      ST_PATCH,
      ST_DONE
   } loader_state_t;

   localparam logic [15:0] ZP_VARTAB = 16'h002A;
   localparam logic [15:0] ZP_ARYTAB = 16'h002C;
   localparam logic [15:0] ZP_STREND = 16'h002E;

`ifdef PET_LOADER_FULLPATCH_EN
   localparam int PATCH_LEN = 6;
`else
   localparam int PATCH_LEN = 2;
`endif

   // Even index writes the low byte of a pointer pair, odd index the high byte.
   function automatic logic [15:0] patch_addr(input logic [2:0] idx);
      logic [15:0] base;
      case (idx[2:1])
         2'd1:    base = ZP_ARYTAB;
         2'd2:    base = ZP_STREND;
         default: base = ZP_VARTAB;
      endcase
      return {base[15:1], idx[0]};
   endfunction

   function automatic logic is_loading(input loader_state_t s);
      return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_PRG_DATA) || (s == ST_ROM_DATA);
   endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Two-requester round-robin arbiter for the DMA write port; prio_ldr forces the
// loader to win and blocks the external requester.
module dma_rr_arb (
   input  logic clk,
   input  logic reset,
   input  logic req_ldr,
   input  logic req_ext,
   input  logic prio_ldr,
   output logic gnt_ldr,
   output logic gnt_ext
);

   logic last_ext;

   always_comb begin
      gnt_ldr = 1'b0;
      gnt_ext = 1'b0;
      if (prio_ldr) begin
         gnt_ldr = req_ldr;
      end else if (req_ldr && req_ext) begin
         if (last_ext) gnt_ldr = 1'b1;
         else          gnt_ext = 1'b1;
      end else begin
         gnt_ldr = req_ldr;
         gnt_ext = req_ext;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        last_ext <= 1'b0;
      else if (gnt_ldr) last_ext <= 1'b0;
      else if (gnt_ext) last_ext <= 1'b1;
   end

endmodule

// File: rtl/pet_dma_loader.sv
// PET DMA write-port loader: PRG/ROM ioctl parsing, BASIC pointer patch and sharing
// with one external requester. PET_LOADER_FULLPATCH_EN widens the patch to 6 bytes.
//
// state    | meaning
// IDLE     | waiting for a rising edge of ioctl_download
// HDR_LO   | next byte is load address [7:0]
// HDR_HI   | next byte is load address [15:8]
// PRG_DATA | PRG payload written at load_addr
// ROM_DATA | ROM image written at 8000-FFFF
// PATCH    | writing end pointer into zero-page pairs
// DONE     | one cycle before releasing the CPU
module pet_dma_loader
   import pet_loader_pkg::*;
#(
   parameter logic [7:0]  PRG_INDEX = 8'h41,
   parameter logic [7:0]  ROM_INDEX = 8'h02,
   parameter logic [15:0] RAM_TOP   = 16'h8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   input  logic        ext_req,
   input  logic [15:0] ext_addr,
   input  logic [7:0]  ext_data,
   output logic        ext_gnt,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_din,
   output logic        dma_we,
   output logic        hold_cpu,
   output logic        busy
);

   loader_state_t state_q, state_d;
   logic        dl_q, dl_rise, dl_fall, dl_end, end_pend;
   logic        loading_q, loading_d;
   logic        buf_valid;
   logic [24:0] buf_addr;
   logic [7:0]  buf_data;
   logic [15:0] load_addr, end_ptr;
   logic [2:0]  patch_idx;
   logic        patch_phase, patch_last;
   logic        prg_in_ram, rom_in_range;
   logic        req_ldr, req_ext, gnt_ldr, gnt_ext;
   logic        accept, consume;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        ovf_sticky;
   logic        dbg_unused;

   assign ioctl_wait = buf_valid;
   assign dbg_unused = ovf_sticky;

   always_comb begin
      dl_rise      = ioctl_download & ~dl_q;
      dl_fall      = ~ioctl_download & dl_q;
      dl_end       = dl_fall | end_pend;
      loading_q    = is_loading(state_q);
      prg_in_ram   = load_addr < RAM_TOP;
      rom_in_range = buf_addr < 25'h0008000;
      patch_last   = patch_idx == 3'(PATCH_LEN - 1);
      accept       = ioctl_wr & loading_q & ~buf_valid;
      // ext_gnt masks the request still held in the cycle the requester sees its grant
      req_ext      = ext_req & ~ext_gnt;
      case (state_q)
         ST_PRG_DATA: req_ldr = buf_valid & prg_in_ram;
         ST_ROM_DATA: req_ldr = buf_valid & rom_in_range;
         ST_PATCH:    req_ldr = ~patch_phase;
         default:     req_ldr = 1'b0;
      endcase
   end

   dma_rr_arb u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_ldr  (req_ldr),
      .req_ext  (req_ext),
      .prio_ldr (state_q == ST_PATCH),
      .gnt_ldr  (gnt_ldr),
      .gnt_ext  (gnt_ext)
   );

   always_comb begin
      state_d = state_q;
      consume = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (gnt_ext) begin
         wr_addr = ext_addr;
         wr_data = ext_data;
      end
      case (state_q)
         ST_IDLE: begin
            if (dl_rise) begin
               if (ioctl_index == PRG_INDEX)      state_d = ST_HDR_LO;
               else if (ioctl_index == ROM_INDEX) state_d = ST_ROM_DATA;
            end
         end
         ST_HDR_LO: begin
            consume = buf_valid;
            if (buf_valid)   state_d = ST_HDR_HI;
            else if (dl_end) state_d = ST_IDLE;
         end
         ST_HDR_HI: begin
            consume = buf_valid;
            if (buf_valid)   state_d = ST_PRG_DATA;
            else if (dl_end) state_d = ST_IDLE;
         end
         ST_PRG_DATA: begin
            consume = buf_valid & (gnt_ldr | ~prg_in_ram);
            if (gnt_ldr) begin
               wr_addr = load_addr;
               wr_data = buf_data;
            end
            if (dl_end && !buf_valid) state_d = ST_PATCH;
         end
         ST_ROM_DATA: begin
            consume = buf_valid & (gnt_ldr | ~rom_in_range);
            if (gnt_ldr) begin
               wr_addr = {1'b1, buf_addr[14:0]};
               wr_data = buf_data;
            end
            if (dl_end && !buf_valid) state_d = ST_IDLE;
         end
         ST_PATCH: begin
            if (gnt_ldr) begin
               wr_addr = patch_addr(patch_idx);
               wr_data = patch_idx[0] ? end_ptr[15:8] : end_ptr[7:0];
               if (patch_last) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      loading_d = is_loading(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         // Starting high means a download still active after reset is not seen as a new edge
         dl_q        <= 1'b1;
         end_pend    <= 1'b0;
         buf_valid   <= 1'b0;
         buf_addr    <= '0;
         buf_data    <= '0;
         load_addr   <= '0;
         end_ptr     <= '0;
         patch_idx   <= '0;
         patch_phase <= 1'b0;
         ovf_sticky  <= 1'b0;
         dma_we      <= 1'b0;
         ext_gnt     <= 1'b0;
         dma_addr    <= '0;
         dma_din     <= '0;
         hold_cpu    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q  <= state_d;
         dl_q     <= ioctl_download;
         end_pend <= loading_d & (end_pend | dl_fall);

         if (consume) begin
            buf_valid <= 1'b0;
         end else if (accept) begin
            buf_valid <= 1'b1;
            buf_addr  <= ioctl_addr;
            buf_data  <= ioctl_dout;
         end
         if (ioctl_wr && loading_q && buf_valid) ovf_sticky <= 1'b1;

         if (state_q == ST_HDR_LO && buf_valid)  load_addr[7:0]  <= buf_data;
         if (state_q == ST_HDR_HI && buf_valid)  load_addr[15:8] <= buf_data;
         if (state_q == ST_PRG_DATA && consume)  load_addr       <= load_addr + 16'd1;
         if (state_q == ST_PRG_DATA && state_d == ST_PATCH)
            end_ptr <= prg_in_ram ? load_addr : RAM_TOP;

         if (state_q != ST_PATCH) begin
            patch_idx   <= '0;
            patch_phase <= 1'b0;
         end else begin
            patch_phase <= ~patch_phase;
            if (gnt_ldr) patch_idx <= patch_idx + 3'd1;
         end

         dma_we   <= gnt_ldr | gnt_ext;
         ext_gnt  <= gnt_ext;
         dma_addr <= wr_addr;
         dma_din  <= wr_data;
         hold_cpu <= (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) || (state_d == ST_PRG_DATA)
                     || (state_d == ST_PATCH) || (state_d == ST_DONE);
         busy     <= state_d != ST_IDLE;
      end
   end

endmodule

// File: tb/tb_pet_dma_loader.sv
// Scoreboard bench for pet_dma_loader: directed downloads push expected DMA writes,
// a negedge monitor pops and compares every dma_we.
module tb_pet_dma_loader;

   logic        clk, reset;
   logic        ioctl_download, ioctl_wr;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;
   logic        ioctl_wait;
   logic        ext_req, ext_gnt;
   logic [15:0] ext_addr;
   logic [7:0]  ext_data;
   logic [15:0] dma_addr;
   logic [7:0]  dma_din;
   logic        dma_we, hold_cpu, busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        ext;
   } wr_t;
   wr_t exp_q[$];
   wr_t e;

   pet_dma_loader dut (
      .clk            (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .ext_req        (ext_req),
      .ext_addr       (ext_addr),
      .ext_data       (ext_data),
      .ext_gnt        (ext_gnt),
      .dma_addr       (dma_addr),
      .dma_din        (dma_din),
      .dma_we         (dma_we),
      .hold_cpu       (hold_cpu),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (ext_gnt && !dma_we) begin
         n_errors++;
         $display("FAIL gnt_without_we: ext_gnt=1 dma_we=0");
      end
      if (dma_we) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h ext=%b, expected none",
                     dma_addr, dma_din, ext_gnt);
         end else begin
            e = exp_q.pop_front();
            if (dma_addr !== e.addr || dma_din !== e.data || ext_gnt !== e.ext) begin
               n_errors++;
               $display("FAIL dma_write: got addr=%h data=%h ext=%b, expected addr=%h data=%h ext=%b",
                        dma_addr, dma_din, ext_gnt, e.addr, e.data, e.ext);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] d, input logic x);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.ext  = x;
      exp_q.push_back(w);
   endtask

   task automatic push_patch(input logic [15:0] p);
      push(16'h002A, p[7:0], 1'b0);
      push(16'h002B, p[15:8], 1'b0);
`ifdef PET_LOADER_FULLPATCH_EN
      push(16'h002C, p[7:0], 1'b0);
      push(16'h002D, p[15:8], 1'b0);
      push(16'h002E, p[7:0], 1'b0);
      push(16'h002F, p[15:8], 1'b0);
`endif
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_byte(input logic [24:0] ofs, input logic [7:0] d, input logic with_ext);
      int n = 0;
      while (ioctl_wait && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("wait_release_timeout", 32'(ioctl_wait), 32'd0);
      ioctl_addr = ofs;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      if (with_ext) begin
         ext_req = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!ext_gnt && n < 20);
         chk("ext_gnt_seen", 32'(ext_gnt), 32'd1);
         chk("bp_wait_held", 32'(ioctl_wait), 32'd1);
         ext_req = 1'b0;
      end
   endtask

   task automatic drop_dl();
      int n = 0;
      while (ioctl_wait && n < 50) begin
         @(negedge clk);
         n++;
      end
      ioctl_download = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index = 8'h00;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = 8'h00;
      ext_req = 1'b0;
      ext_addr = 16'h1234;
      ext_data = 8'h5A;
      #3;
      chk("reset_outputs", 32'({ioctl_wait, ext_gnt, dma_we, dma_addr, dma_din, hold_cpu, busy}), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // PRG load 01 04 AA BB CC
      push(16'h0401, 8'hAA, 1'b0);
      push(16'h0402, 8'hBB, 1'b0);
      push(16'h0403, 8'hCC, 1'b0);
      push_patch(16'h0404);
      start_dl(8'h41);
      chk("prg_hold_on", 32'(hold_cpu), 32'd1);
      chk("prg_busy_on", 32'(busy), 32'd1);
      send_byte(25'd0, 8'h01, 1'b0);
      send_byte(25'd1, 8'h04, 1'b0);
      send_byte(25'd2, 8'hAA, 1'b0);
      send_byte(25'd3, 8'hBB, 1'b0);
      send_byte(25'd4, 8'hCC, 1'b0);
      chk("prg_hold_mid", 32'(hold_cpu), 32'd1);
      drop_dl();
      wait_idle("prg_idle");
      chk("prg_hold_off", 32'(hold_cpu), 32'd0);
      chk("prg_drained", 32'(exp_q.size()), 32'd0);

      // top-of-RAM clip: header FE 7F, 4 payload bytes
      push(16'h7FFE, 8'h01, 1'b0);
      push(16'h7FFF, 8'h02, 1'b0);
      push_patch(16'h8000);
      start_dl(8'h41);
      send_byte(25'd0, 8'hFE, 1'b0);
      send_byte(25'd1, 8'h7F, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(25'(i + 2), 8'(i + 1), 1'b0);
      drop_dl();
      wait_idle("clip_idle");
      chk("clip_drained", 32'(exp_q.size()), 32'd0);

      // ROM load
      push(16'h8000, 8'h11, 1'b0);
      push(16'hFFFF, 8'h22, 1'b0);
      start_dl(8'h02);
      chk("rom_hold_off", 32'(hold_cpu), 32'd0);
      chk("rom_busy_on", 32'(busy), 32'd1);
      send_byte(25'h0000000, 8'h11, 1'b0);
      send_byte(25'h0007FFF, 8'h22, 1'b0);
      send_byte(25'h0008000, 8'h33, 1'b0);
      chk("rom_hold_mid", 32'(hold_cpu), 32'd0);
      drop_dl();
      wait_idle("rom_idle");
      chk("rom_drained", 32'(exp_q.size()), 32'd0);

      // back-pressure and arbitration: ext request raised while each byte waits
      push(16'h1234, 8'h5A, 1'b1); push(16'h1000, 8'h11, 1'b0);
      push(16'h1234, 8'h5A, 1'b1); push(16'h1001, 8'h22, 1'b0);
      push(16'h1234, 8'h5A, 1'b1); push(16'h1002, 8'h33, 1'b0);
      push_patch(16'h1003);
      start_dl(8'h41);
      send_byte(25'd0, 8'h00, 1'b0);
      send_byte(25'd1, 8'h10, 1'b0);
      send_byte(25'd2, 8'h11, 1'b1);
      send_byte(25'd3, 8'h22, 1'b1);
      send_byte(25'd4, 8'h33, 1'b1);
      drop_dl();
      wait_idle("arb_idle");
      chk("arb_drained", 32'(exp_q.size()), 32'd0);
      chk("ovf_sticky", 32'(dut.ovf_sticky), 32'd0);

      // short PRG download and an unknown index: no writes
      start_dl(8'h41);
      send_byte(25'd0, 8'h05, 1'b0);
      drop_dl();
      wait_idle("short_idle");
      chk("short_hold_off", 32'(hold_cpu), 32'd0);
      start_dl(8'h10);
      chk("other_idx_busy", 32'(busy), 32'd0);
      send_byte(25'd0, 8'h99, 1'b0);
      drop_dl();
      chk("other_idx_wait", 32'(ioctl_wait), 32'd0);

      // reset during PATCH right after the 0x2A write
      push(16'h2000, 8'h77, 1'b0);
      push(16'h002A, 8'h01, 1'b0);
      start_dl(8'h41);
      send_byte(25'd0, 8'h00, 1'b0);
      send_byte(25'd1, 8'h20, 1'b0);
      send_byte(25'd2, 8'h77, 1'b0);
      drop_dl();
      n = 0;
      while (!(dma_we && dma_addr == 16'h002A) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_saw_2a", 32'(n < 100), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_outputs", 32'({ioctl_wait, ext_gnt, dma_we, dma_addr, dma_din, hold_cpu, busy}), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
